// File: rtl/cb_dequantizer_if.sv
// cb_dequantizer_if: coefficient stream in, reconstructed 8x8 Cb block out.
interface cb_dequantizer_if #(parameter int DATA_W = 11);
  logic enable;
  logic signed [DATA_W-1:0] coef_in;
  logic [0:7][0:7][DATA_W-1:0] Dq;
  logic out_enable;
  logic busy;
  modport master(output enable, coef_in, input Dq, out_enable, busy);
  modport slave(input enable, coef_in, output Dq, out_enable, busy);
endinterface

// File: rtl/cb_dequantizer.sv
// cb_dequantizer: streaming Cb inverse quantizer, 3-stage pipeline into a registered 8x8 block.
module cb_dequantizer #(
  parameter int DATA_W = 11,
  parameter int PROD_W = 18
) (
  input logic clk,
  input logic rst,
  cb_dequantizer_if.slave bus
);
  localparam logic [7:0] Q_CHROMA [64] = '{
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
  };
  localparam logic signed [PROD_W-1:0] MAX_V = PROD_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] MIN_V = ~MAX_V;
  logic [5:0] k, s1_k, s2_k, s3_k;
  logic s1_v, s2_v, s3_v;
  logic signed [DATA_W-1:0] s1_c, s3_d, sat_d;
  logic signed [PROD_W-1:0] s2_p, prod;
  logic [0:63][DATA_W-1:0] asm_buf, blk;
  logic commit;
  assign prod = PROD_W'(s1_c) * PROD_W'($signed({1'b0, Q_CHROMA[s1_k]}));
  assign sat_d = s2_p > MAX_V ? MAX_V[DATA_W-1:0] : s2_p < MIN_V ? MIN_V[DATA_W-1:0] : s2_p[DATA_W-1:0];
  assign commit = s3_v && s3_k == 6'd63;
  assign bus.busy = k != 6'd0 || s1_v || s2_v || s3_v;
  // the entry being written this edge bypasses the buffer so the commit sees it
  always_comb begin
    blk = asm_buf;
    blk[63] = s3_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
      {s1_v, s2_v, s3_v} <= '0;
      {s1_k, s2_k, s3_k} <= '0;
      s1_c <= '0;
      s2_p <= '0;
      s3_d <= '0;
      asm_buf <= '0;
      bus.Dq <= '0;
      bus.out_enable <= 1'b0;
    end else begin
      k <= bus.enable ? k + 6'd1 : k;
      s1_v <= bus.enable;
      s1_k <= k;
      s1_c <= bus.coef_in;
      s2_v <= s1_v;
      s2_k <= s1_k;
      s2_p <= prod;
      s3_v <= s2_v;
      s3_k <= s2_k;
      s3_d <= sat_d;
      if (s3_v) asm_buf[s3_k] <= s3_d;
      if (commit) bus.Dq <= blk;
      bus.out_enable <= commit;
    end
  end
endmodule
